// File: rtl/uart_ctrl_if.sv
// uart_ctrl_if: bus-side and UART-side signal bundle for uart_ctrl.
// Latency: none, wires only.
// Backpressure: none here; overflow handling lives in uart_ctrl.
interface uart_ctrl_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  RX_DATA;
  logic        RX_STATUS;
  logic        TX_STATUS;
  logic [7:0]  TX_DATA;
  logic        ctrl;
  logic        irqout;

  // Controller side
  modport slave (
    input  rd, wr, addr, wdata, RX_DATA, RX_STATUS, TX_STATUS,
    output rdata, TX_DATA, ctrl, irqout
  );

  // Bus master / UART PHY side
  modport master (
    output rd, wr, addr, wdata, RX_DATA, RX_STATUS, TX_STATUS,
    input  rdata, TX_DATA, ctrl, irqout
  );
endinterface

// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped UART controller (TX FIFO + start FSM, RX holding buffer, IRQ).
// Latency: TXD write to ctrl pulse 2 cycles with idle transmitter; rdata is combinational.
// Backpressure: full TX FIFO drops the byte and sets tx_ovf; unread RX byte is overwritten and sets rx_ovr.
module uart_ctrl #(
  parameter int unsigned TX_DEPTH = 4,
  parameter logic [31:0] BASE     = 32'h40000018
) (
  input logic        clk,
  input logic        reset,
  uart_ctrl_if.slave bus
);
  localparam int unsigned   PW       = $clog2(TX_DEPTH);
  localparam int unsigned   CW       = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TX_DEPTH);
  localparam logic [31:0]   TXD_A    = BASE;
  localparam logic [31:0]   RXD_A    = BASE + 32'd4;
  localparam logic [31:0]   CON_A    = BASE + 32'd8;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE} tx_state_t;

  tx_state_t     r_state, w_next;
  logic [7:0]    r_fifo [TX_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_tx_data, r_rx_buf;
  logic          r_ie_tx, r_ie_rx, r_tx_done, r_rx_ready, r_tx_ovf, r_rx_ovr, r_irq;

  logic w_push, w_pop, w_full, w_accept, w_drop;
  logic w_rd_rxd, w_rd_con, w_wr_con, w_tx_fin, w_tx_busy, w_ctrl;
  logic [31:0] w_rdata;
  logic w_unused;

  assign w_push    = bus.wr && (bus.addr == TXD_A);
  assign w_wr_con  = bus.wr && (bus.addr == CON_A);
  assign w_rd_rxd  = bus.rd && (bus.addr == RXD_A);
  assign w_rd_con  = bus.rd && (bus.addr == CON_A);
  assign w_full    = (r_cnt == FULL_CNT);
  assign w_pop     = (r_state == S_IDLE) && (r_cnt != '0) && bus.TX_STATUS;
  // A pop frees a slot in the same cycle, so a write into a full FIFO still lands.
  assign w_accept  = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;
  assign w_tx_fin  = (r_state == S_WAIT_DONE) && bus.TX_STATUS;
  assign w_tx_busy = (r_state != S_IDLE) || (r_cnt != '0);
  assign w_unused  = ^{bus.wdata[31:8]};

  // TX FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // TX FSM next state and start pulse
  always_comb begin
    w_next = r_state;
    w_ctrl = 1'b0;
    case (r_state)
      S_IDLE:      if (w_pop) w_next = S_LOAD;
      S_LOAD: begin
        w_ctrl = 1'b1;
        w_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: if (!bus.TX_STATUS) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (bus.TX_STATUS) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    if (w_accept) r_fifo[r_wptr] <= bus.wdata[7:0];
  end

  // FIFO pointers, occupancy and the byte latched for the transmitter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_tx_data <= 8'h00;
    end else begin
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr    <= r_rptr + 1'b1;
        r_tx_data <= r_fifo[r_rptr];
      end
      case ({w_accept, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // CON flags and RX buffer; set events take priority over read-to-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ie_tx    <= 1'b0;
      r_ie_rx    <= 1'b0;
      r_tx_done  <= 1'b0;
      r_rx_ready <= 1'b0;
      r_tx_ovf   <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_buf   <= 8'h00;
    end else begin
      if (w_wr_con) begin
        r_ie_tx <= bus.wdata[0];
        r_ie_rx <= bus.wdata[1];
      end
      if (w_tx_fin)      r_tx_done <= 1'b1;
      else if (w_rd_con) r_tx_done <= 1'b0;
      if (w_drop)        r_tx_ovf <= 1'b1;
      else if (w_rd_con) r_tx_ovf <= 1'b0;
      // A byte arriving while the old one is being read is not an overrun.
      if (bus.RX_STATUS && r_rx_ready && !w_rd_rxd) r_rx_ovr <= 1'b1;
      else if (w_rd_con)                            r_rx_ovr <= 1'b0;
      if (bus.RX_STATUS) begin
        r_rx_buf   <= bus.RX_DATA;
        r_rx_ready <= 1'b1;
      end else if (w_rd_rxd) begin
        r_rx_ready <= 1'b0;
      end
    end
  end

  // Registered interrupt request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= (r_ie_tx & r_tx_done) | (r_ie_rx & r_rx_ready);
  end

  // Combinational read mux; zero when not reading or unmapped
  always_comb begin
    w_rdata = 32'h0;
    if (bus.rd) begin
      if (bus.addr == TXD_A)      w_rdata = {24'h0, r_tx_data};
      else if (bus.addr == RXD_A) w_rdata = {24'h0, r_rx_buf};
      else if (bus.addr == CON_A)
        w_rdata = {25'h0, r_rx_ovr, r_tx_ovf, w_tx_busy, r_rx_ready, r_tx_done, r_ie_rx, r_ie_tx};
    end
  end

  assign bus.rdata   = w_rdata;
  assign bus.TX_DATA = r_tx_data;
  assign bus.ctrl    = w_ctrl;
  assign bus.irqout  = r_irq;
endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: scoreboard bench for uart_ctrl.
// Latency: expectations queued at stimulus time, popped by monitors when rd or ctrl is seen.
// Backpressure: transmitter idle/busy is emulated by driving TX_STATUS from the stimulus.
module tb_uart_ctrl;
  localparam logic [31:0] TXD = 32'h40000018;
  localparam logic [31:0] RXD = 32'h4000001C;
  localparam logic [31:0] CON = 32'h40000020;

  typedef struct {
    string       nm;
    logic [31:0] v;
  } exp_t;

  logic clk;
  logic reset;
  uart_ctrl_if ifc();

  uart_ctrl #(.TX_DEPTH(4), .BASE(32'h40000018)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int total = 0;
  int bad   = 0;
  exp_t       rq[$];
  logic [7:0] txq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Read-response monitor
  always @(negedge clk) begin
    if (ifc.rd === 1'b1) begin
      if (rq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rd_unexpected: got read of 0x%08h, want no read", ifc.addr);
      end else begin
        exp_t e;
        e = rq.pop_front();
        chk(e.nm, ifc.rdata, e.v);
      end
    end
  end

  // Transmit-start monitor: every ctrl cycle must match one queued byte
  always @(negedge clk) begin
    if (ifc.ctrl === 1'b1) begin
      if (txq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ctrl_unexpected: got pulse with TX_DATA=0x%02h, want no pulse", ifc.TX_DATA);
      end else begin
        logic [7:0] b;
        b = txq.pop_front();
        chk("tx_byte", {24'h0, ifc.TX_DATA}, {24'h0, b});
      end
    end
  end

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    ifc.wr = 1'b1; ifc.addr = a; ifc.wdata = d;
    @(posedge clk); #1;
    ifc.wr = 1'b0; ifc.addr = 32'h0; ifc.wdata = 32'h0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    exp_t x;
    x.nm = nm; x.v = e;
    @(posedge clk); #1;
    rq.push_back(x);
    ifc.rd = 1'b1; ifc.addr = a;
    @(posedge clk); #1;
    ifc.rd = 1'b0; ifc.addr = 32'h0;
  endtask

  task automatic rx_pulse(input logic [7:0] d);
    @(posedge clk); #1;
    ifc.RX_STATUS = 1'b1; ifc.RX_DATA = d;
    @(posedge clk); #1;
    ifc.RX_STATUS = 1'b0; ifc.RX_DATA = 8'h00;
  endtask

  task automatic wait_ctrl(input string nm);
    int k;
    k = 0;
    @(negedge clk);
    while (ifc.ctrl !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(nm, {31'h0, ifc.ctrl}, 32'h1);
  endtask

  // Emulated transmitter: busy for two cycles after the start pulse, then idle
  task automatic tx_cycle();
    @(posedge clk); #1 ifc.TX_STATUS = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 ifc.TX_STATUS = 1'b1;
  endtask

  initial begin
    exp_t x;
    reset = 1'b1;
    ifc.rd = 1'b0; ifc.wr = 1'b0; ifc.addr = 32'h0; ifc.wdata = 32'h0;
    ifc.RX_DATA = 8'h00; ifc.RX_STATUS = 1'b0; ifc.TX_STATUS = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_txdata", {24'h0, ifc.TX_DATA}, 32'h0);
    chk("rst_ctrl", {31'h0, ifc.ctrl}, 32'h0);
    chk("rst_irq", {31'h0, ifc.irqout}, 32'h0);
    bus_rd(CON, 32'h0, "rst_con");
    bus_rd(RXD, 32'h0, "rst_rxd");
    @(posedge clk); #1 reset = 1'b0;

    // Single byte with idle transmitter
    txq.push_back(8'h55);
    bus_wr(TXD, 32'hABCD_0055);
    bus_rd(CON, 32'h10, "s1_busy");
    chk("s1_txdata", {24'h0, ifc.TX_DATA}, 32'h55);
    tx_cycle();
    repeat (2) @(posedge clk);
    bus_rd(TXD, 32'h55, "s1_txd_hold");
    bus_rd(CON, 32'h04, "s1_done");
    bus_rd(CON, 32'h00, "s1_done_clr");

    // FIFO overflow with busy transmitter, then in-order drain
    ifc.TX_STATUS = 1'b0;
    for (int i = 1; i <= 5; i++) bus_wr(TXD, i);
    bus_rd(CON, 32'h30, "s2_ovf");
    bus_wr(CON, 32'h1);
    for (int i = 1; i <= 4; i++) txq.push_back(8'(i));
    ifc.TX_STATUS = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_ctrl("s2_ctrl_seen");
      tx_cycle();
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("s2_irq_tx", {31'h0, ifc.irqout}, 32'h1);
    bus_rd(CON, 32'h05, "s2_con_done");
    repeat (2) @(negedge clk);
    chk("s2_irq_clr", {31'h0, ifc.irqout}, 32'h0);

    // RX byte with interrupt
    bus_wr(CON, 32'hFFFF_FF02);
    rx_pulse(8'hA3);
    @(negedge clk);
    chk("s3_irq_lag", {31'h0, ifc.irqout}, 32'h0);
    @(negedge clk);
    chk("s3_irq_set", {31'h0, ifc.irqout}, 32'h1);
    bus_rd(RXD, 32'hA3, "s3_rxd");
    repeat (2) @(negedge clk);
    chk("s3_irq_clr", {31'h0, ifc.irqout}, 32'h0);
    bus_rd(CON, 32'h02, "s3_con");

    // Overrun
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    bus_rd(CON + 32'd4, 32'h0, "s4_unmapped");
    bus_rd(CON, 32'h4A, "s4_ovr");
    bus_rd(RXD, 32'h22, "s4_rxd");
    bus_rd(CON, 32'h02, "s4_ovr_clr");

    // Read coincident with a new byte: no overrun, ready stays
    rx_pulse(8'h33);
    @(posedge clk); #1;
    x.nm = "s5_rxd_old"; x.v = 32'h33;
    rq.push_back(x);
    ifc.rd = 1'b1; ifc.addr = RXD; ifc.RX_STATUS = 1'b1; ifc.RX_DATA = 8'h7E;
    @(posedge clk); #1;
    ifc.rd = 1'b0; ifc.addr = 32'h0; ifc.RX_STATUS = 1'b0; ifc.RX_DATA = 8'h00;
    bus_rd(CON, 32'h0A, "s5_con");
    bus_rd(RXD, 32'h7E, "s5_rxd_new");
    bus_rd(CON, 32'h02, "s5_con_clr");

    // Reset in WAIT_DONE with two bytes queued
    txq.push_back(8'hA1);
    bus_wr(TXD, 32'hA1);
    wait_ctrl("s6_ctrl_seen");
    @(posedge clk); #1 ifc.TX_STATUS = 1'b0;
    bus_wr(TXD, 32'hB2);
    bus_wr(TXD, 32'hC3);
    rx_pulse(8'h5A);
    repeat (2) @(negedge clk);
    chk("s6_irq_pre", {31'h0, ifc.irqout}, 32'h1);
    chk("s6_txdata_pre", {24'h0, ifc.TX_DATA}, 32'hA1);
    bus_rd(CON, 32'h1A, "s6_con_pre");
    ifc.TX_STATUS = 1'b1;
    @(negedge clk); #1 reset = 1'b1;
    #1;
    chk("s6_rst_txdata", {24'h0, ifc.TX_DATA}, 32'h0);
    chk("s6_rst_ctrl", {31'h0, ifc.ctrl}, 32'h0);
    chk("s6_rst_irq", {31'h0, ifc.irqout}, 32'h0);
    bus_rd(CON, 32'h0, "s6_rst_con");
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    bus_rd(CON, 32'h0, "s6_post_con");
    txq.push_back(8'h99);
    bus_wr(TXD, 32'h99);
    wait_ctrl("s6_ctrl_new");
    @(posedge clk); #1;

    chk("txq_drain", txq.size(), 32'h0);
    chk("rq_drain", rq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "timeout");
  end
endmodule
